// File: rtl/gshare_predictor_pkg.sv
// Shared types and default sizes for the gshare branch direction predictor.
// pred_meta_t is sized by the GSHARE_* defaults; instantiate with matching IDX_W/GHR_W.
package gshare_predictor_pkg;

    localparam int GSHARE_CTR_W = 2;
    localparam int GSHARE_IDX_W = 8;
    localparam int GSHARE_GHR_W = 8;

    typedef struct packed {
        logic [GSHARE_IDX_W-1:0] idx;
        logic [GSHARE_GHR_W-1:0] ghr;
    } pred_meta_t;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int ctr_init_value(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and resolve-side update signals of the gshare predictor.
interface gshare_predictor_if #(
    parameter int PC_W = 32
);
    import gshare_predictor_pkg::*;

    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    pred_meta_t      pred_meta;

    logic            upd_valid;
    logic            upd_taken;
    logic            upd_mispredict;
    pred_meta_t      upd_meta;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_taken, upd_mispredict, upd_meta,
        input  pred_taken, pred_meta
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_taken, upd_mispredict, upd_meta,
        output pred_taken, pred_meta
    );

endinterface

// File: rtl/gshare_predictor_sat_counter.sv
// One saturating up/down direction counter of the predictor table.
module sat_counter
    import gshare_predictor_pkg::*;
#(
    parameter int CTR_W = GSHARE_CTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic             dir,
    output logic [CTR_W-1:0] value
);

    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init_value(CTR_W));
    localparam logic [CTR_W-1:0] MAX_VAL  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] MIN_VAL  = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] ONE      = CTR_W'(1);

    logic [CTR_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= INIT_VAL;
        end else if (inc_en) begin
            // Hold at either end instead of wrapping.
            if (dir && (r_value != MAX_VAL)) begin
                r_value <= r_value + ONE;
            end else if (!dir && (r_value != MIN_VAL)) begin
                r_value <= r_value - ONE;
            end
        end
    end

    assign value = r_value;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare predictor: PC xor global history indexes a table of saturating counters.
// Define GSHARE_GHR_EN for gshare; leave it undefined for a plain bimodal table.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int CTR_W = GSHARE_CTR_W,
    parameter int IDX_W = GSHARE_IDX_W,
    parameter int GHR_W = GSHARE_GHR_W,
    parameter int PC_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    gshare_predictor_if.slave    bus
);

    localparam int NUM_CTR = 1 << IDX_W;

    logic [CTR_W-1:0] w_ctr [NUM_CTR];
    logic [NUM_CTR-1:0] w_wr_en;
    logic [IDX_W-1:0] w_pc_idx;
    logic [IDX_W-1:0] w_idx;
    logic [GHR_W-1:0] w_meta_ghr;
    logic             w_pred_taken;
    logic             w_unused;

    assign w_pc_idx = bus.pred_pc[IDX_W+1:2];

`ifdef GSHARE_GHR_EN
    logic [GHR_W-1:0] r_ghr;

    assign w_idx      = w_pc_idx ^ IDX_W'(r_ghr);
    assign w_meta_ghr = r_ghr;

    // A resolved mispredict rebuilds history from its snapshot, beating any same-cycle shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (bus.upd_valid && bus.upd_mispredict) begin
            r_ghr <= {bus.upd_meta.ghr[GHR_W-2:0], bus.upd_taken};
        end else if (bus.pred_valid) begin
            r_ghr <= {r_ghr[GHR_W-2:0], w_pred_taken};
        end
    end

    assign w_unused = ^{bus.pred_pc[1:0], bus.pred_pc[PC_W-1:IDX_W+2],
                        bus.upd_meta.ghr[GHR_W-1]};
`else
    assign w_idx      = w_pc_idx;
    assign w_meta_ghr = '0;

    assign w_unused = ^{bus.pred_pc[1:0], bus.pred_pc[PC_W-1:IDX_W+2],
                        bus.upd_meta.ghr, bus.upd_mispredict};
`endif

    // Counter reads see pre-update state, so a same-index update lands next cycle.
    assign w_pred_taken   = w_ctr[w_idx][CTR_W-1];
    assign bus.pred_taken = w_pred_taken;
    assign bus.pred_meta  = '{idx: w_idx, ghr: w_meta_ghr};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTR; gi++) begin : g_ctr
            assign w_wr_en[gi] = bus.upd_valid && (bus.upd_meta.idx == IDX_W'(gi));

            sat_counter #(
                .CTR_W (CTR_W)
            ) u_ctr (
                .clk    (clk),
                .reset  (reset),
                .inc_en (w_wr_en[gi]),
                .dir    (bus.upd_taken),
                .value  (w_ctr[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor; expectations adapt to GSHARE_GHR_EN.
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

`ifdef GSHARE_GHR_EN
    localparam bit GHR_ON = 1'b1;
`else
    localparam bit GHR_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    gshare_predictor_if #(.PC_W(32)) bus ();

    gshare_predictor #(
        .CTR_W (2),
        .IDX_W (8),
        .GHR_W (8),
        .PC_W  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pred(input logic [7:0] idx, input logic [7:0] exp_g);
        logic [7:0] g;
        g = GHR_ON ? exp_g : 8'h00;
        bus.pred_valid = 1'b1;
        bus.pred_pc    = {22'd0, idx ^ g, 2'b00};
    endtask

    task automatic check_pred(input logic [7:0] idx, input logic exp_t,
                              input logic [7:0] exp_g, input string tag);
        logic [7:0] g;
        g = GHR_ON ? exp_g : 8'h00;
        chk({tag, ".taken"}, 32'(bus.pred_taken), 32'(exp_t));
        chk({tag, ".idx"},   32'(bus.pred_meta.idx), 32'(idx));
        chk({tag, ".ghr"},   32'(bus.pred_meta.ghr), 32'(g));
        $display("pred %s idx=%02h ghr=%02h taken=%0b", tag,
                 bus.pred_meta.idx, bus.pred_meta.ghr, bus.pred_taken);
    endtask

    task automatic predict(input logic [7:0] idx, input logic exp_t,
                           input logic [7:0] exp_g, input string tag);
        drive_pred(idx, exp_g);
        #1;
        check_pred(idx, exp_t, exp_g, tag);
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
    endtask

    task automatic drive_upd(input logic [7:0] idx, input logic taken,
                             input logic mis, input logic [7:0] ghr);
        bus.upd_valid      = 1'b1;
        bus.upd_taken      = taken;
        bus.upd_mispredict = mis;
        bus.upd_meta       = '{idx: idx, ghr: ghr};
    endtask

    task automatic clear_upd();
        bus.upd_valid      = 1'b0;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.upd_meta       = '0;
    endtask

    task automatic update(input logic [7:0] idx, input logic taken,
                          input logic mis, input logic [7:0] ghr);
        drive_upd(idx, taken, mis, ghr);
        @(posedge clk);
        #1;
        $display("upd idx=%02h taken=%0b mis=%0b ghr=%02h", idx, taken, mis, ghr);
        clear_upd();
    endtask

    task automatic both(input logic [7:0] pidx, input logic exp_t, input logic [7:0] exp_g,
                        input logic [7:0] uidx, input logic taken, input logic mis,
                        input logic [7:0] ughr, input string tag);
        drive_pred(pidx, exp_g);
        drive_upd(uidx, taken, mis, ughr);
        #1;
        check_pred(pidx, exp_t, exp_g, tag);
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        clear_upd();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        clear_upd();

        // Reset wins over concurrent traffic.
        reset = 1'b1;
        drive_pred(8'h40, 8'h00);
        drive_upd(8'h40, 1'b1, 1'b1, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pred_valid = 1'b0;
        clear_upd();

        predict(8'h40, 1'b0, 8'h00, "rst_pred");
        update(8'h40, 1'b1, 1'b0, 8'h00);
        predict(8'h40, 1'b1, 8'h00, "inc1");
        update(8'h40, 1'b1, 1'b0, 8'h00);
        update(8'h40, 1'b1, 1'b0, 8'h00);
        predict(8'h40, 1'b1, 8'h01, "sat_hi");
        update(8'h40, 1'b0, 1'b0, 8'h00);
        predict(8'h40, 1'b1, 8'h03, "dec1");
        update(8'h40, 1'b0, 1'b0, 8'h00);
        predict(8'h40, 1'b0, 8'h07, "dec2");
        update(8'h40, 1'b0, 1'b0, 8'h00);
        update(8'h40, 1'b0, 1'b0, 8'h00);
        update(8'h40, 1'b1, 1'b0, 8'h00);
        predict(8'h40, 1'b0, 8'h0E, "sat_lo_a");
        update(8'h40, 1'b1, 1'b0, 8'h00);
        predict(8'h40, 1'b1, 8'h1C, "sat_lo_b");

        // History back to zero, counter 0x40 to strongly taken, then five taken predictions.
        update(8'h10, 1'b0, 1'b1, 8'h00);
        update(8'h40, 1'b1, 1'b0, 8'h00);
        predict(8'h40, 1'b1, 8'h00, "hist0");
        predict(8'h40, 1'b1, 8'h01, "hist1");
        predict(8'h40, 1'b1, 8'h03, "hist2");
        predict(8'h40, 1'b1, 8'h07, "hist3");
        predict(8'h40, 1'b1, 8'h0F, "hist4");
        update(8'h20, 1'b0, 1'b1, 8'h03);
        predict(8'h40, 1'b1, 8'h06, "restore");

        both(8'h40, 1'b1, 8'h0D, 8'h30, 1'b1, 1'b1, 8'h0A, "prio_same");
        predict(8'h40, 1'b1, 8'h15, "prio");

        // Mispredict with upd_valid low must be ignored.
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b1;
        bus.upd_taken      = 1'b1;
        bus.upd_meta       = '{idx: 8'h77, ghr: 8'hFF};
        predict(8'h40, 1'b1, 8'h2B, "ign_mis");
        clear_upd();
        predict(8'h40, 1'b1, 8'h57, "ign_mis2");
        predict(8'h77, 1'b0, 8'hAF, "no_train");

        both(8'h50, 1'b0, 8'h5E, 8'h50, 1'b1, 1'b0, 8'h00, "hazard");
        predict(8'h50, 1'b1, 8'hBC, "haz_next");
        predict(8'h30, 1'b1, 8'h79, "train30");
        predict(8'h10, 1'b0, 8'hF3, "ctr10_lo");
        predict(8'h20, 1'b0, 8'hE6, "ctr20_lo");

        // Reset in the middle of back-to-back updates.
        drive_pred(8'h40, 8'h00);
        drive_upd(8'h10, 1'b1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pred_valid = 1'b0;
        clear_upd();

        predict(8'h40, 1'b0, 8'h00, "rst_ctr40");
        predict(8'h30, 1'b0, 8'h00, "rst_ctr30");
        predict(8'h10, 1'b0, 8'h00, "rst_ctr10");
        predict(8'h50, 1'b0, 8'h00, "rst_ctr50");
        update(8'h20, 1'b1, 1'b0, 8'h00);
        predict(8'h20, 1'b1, 8'h00, "rst_ctr20");
        update(8'h10, 1'b1, 1'b0, 8'h00);
        predict(8'h10, 1'b1, 8'h01, "rst_ctr10_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter CTR_W, default 2: saturating counter width in bits, legal range 2..4.
REQ-002 SHALL have parameter IDX_W, default 8: table index width, giving 2^IDX_W counters.
REQ-003 SHALL have parameter GHR_W, default 8: global history width, where GHR_W <= IDX_W.
REQ-004 SHALL have parameter PC_W, default 32: program counter width.
REQ-005 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pred_valid, input, 1 bit: fetch is presenting a conditional branch this cycle.
REQ-008 SHALL have port pred_pc, input, PC_W bits: PC of that branch.
REQ-009 SHALL have port pred_taken, output, 1 bit: predicted direction.
REQ-010 SHALL have port pred_meta, output, pred_meta_t: {idx, ghr} snapshot that fetch carries down the pipeline with the branch.
REQ-011 SHALL have port upd_valid, input, 1 bit: a branch has resolved this cycle.
REQ-012 SHALL have port upd_taken, input, 1 bit: actual direction of the resolved branch.
REQ-013 SHALL have port upd_mispredict, input, 1 bit: the resolved branch was mispredicted.
REQ-014 SHALL have port upd_meta, input, pred_meta_t: the snapshot returned with the resolved branch.

Function
REQ-015 Index computation: idx = pred_pc[IDX_W+1:2] XOR {zero-extended ghr}.
REQ-016 Prediction: pred_taken = MSB of counter[idx], purely combinational from current state, zero-cycle latency; pred_meta = {idx, current ghr}.
REQ-017 pred_taken and pred_meta are don't-care when pred_valid=0, and the block SHALL hold no state change for that cycle.
REQ-018 Speculative history: when pred_valid=1, ghr <= {ghr[GHR_W-2:0], pred_taken} at the next edge.
REQ-019 Counter training: when upd_valid=1, counter[upd_meta.idx] increments if upd_taken=1 and decrements if upd_taken=0.
REQ-020 Counter saturation: a counter saturates at 2^CTR_W-1 and at 0, and never wraps.
REQ-021 Recovery: when upd_valid=1 and upd_mispredict=1, ghr <= {upd_meta.ghr[GHR_W-2:0], upd_taken}.
REQ-022 Recovery priority: the REQ-021 restore takes priority over a same-cycle REQ-018 shift.
REQ-023 Same-cycle hazard: with pred_valid=1 and upd_valid=1 in the same cycle and pred idx == upd_meta.idx, the prediction SHALL use the pre-update counter value; the update becomes visible next cycle.
REQ-024 Only one counter SHALL be written per cycle.
REQ-025 upd_mispredict is ignored when upd_valid=0.

Reset
REQ-026 While reset=1, every counter SHALL be set to 2^(CTR_W-1)-1 (weakly not-taken; 2'b01 at default) and ghr SHALL be set to 0.
REQ-027 Reset SHALL override any concurrent pred_valid/upd_valid, including reset mid-stream.
REQ-028 In the first cycle after reset deassertion, pred_taken=0 and pred_meta.ghr=0.

Configuration
REQ-029 Macro GSHARE_GHR_EN defined: behaviour SHALL be as REQ-015/018/021 (gshare).
REQ-030 Macro GSHARE_GHR_EN undefined: the ghr register SHALL be removed, idx = pred_pc[IDX_W+1:2] (pure bimodal), pred_meta.ghr is driven to 0, upd_meta.ghr is ignored, and recovery only affects training.

Structure
REQ-031 pred_meta_t (packed: idx [IDX_W-1:0], ghr [GHR_W-1:0]) SHALL live in the shared structs package, together with the default CTR_W, IDX_W and GHR_W constants.
REQ-032 Counter table SHALL be flops; one sub-module sat_counter (parameter CTR_W; ports clk, reset, inc_en, dir, value) SHALL be generated 2^IDX_W times.

Verification (defaults; GSHARE_GHR_EN defined)
REQ-033 Reset, then pred_valid with pc=0x100 -> pred_taken=0, pred_meta={idx=0x40, ghr=0x00}.
REQ-034 Train counter at idx 0x40 with upd_taken=1 ×3 -> values 01→10→11→11 (saturates); next prediction for that idx =1. Then ×4 not-taken -> 11→10→01→00→00 (saturates at 0).
REQ-035 Five predictions all taken from ghr=0 -> ghr=0x1F; then mispredict update with upd_meta.ghr=0x03, upd_taken=0 -> ghr=0x06 next cycle.
REQ-036 Same cycle: pred_valid (pred_taken=1) plus mispredict update with upd_meta.ghr=0x0A, upd_taken=1 -> ghr=0x15 (restore wins over the shift).
REQ-037 Same cycle: predict and update at the same idx, counter=01, upd_taken=1 -> pred_taken=0 this cycle, and 1 next cycle.
REQ-038 Assert reset during back-to-back updates -> all counters=01 and ghr=0 the cycle after reset; repeat the bench with GSHARE_GHR_EN undefined -> pred_meta.ghr stays 0 and idx = pc[9:2].
